// File: rtl/wts_dac_pkg.sv
// Shared types, constants and the gain-scaling helper for the wts_dsm_dac block.
package wts_dac_pkg;

    typedef enum logic [1:0] {
        PLAY     = 2'd0,
        FADE_OUT = 2'd1,
        MUTED    = 2'd2,
        FADE_IN  = 2'd3
    } wts_state_e;

    localparam logic [11:0] WTS_MIDSCALE = 12'h800;
    localparam logic [4:0]  WTS_GAIN_MAX = 5'd16;

    // Offset-binary sample times gain/16, floor-rounded, back to offset binary.
    function automatic logic [11:0] wts_scale(input logic [11:0] smp, input logic [4:0] gain);
        logic signed [11:0] s;
        logic signed [16:0] p;
        logic [11:0]        r;
        s = {~smp[11], smp[10:0]};
        p = 17'(s) * $signed({12'd0, gain});
        r = 12'(p >>> 4);
        return {~r[11], r[10:0]};
    endfunction

endpackage

// File: rtl/wts_dsm1.sv
// One channel of the first-order delta-sigma modulator: scaled-sample register,
// 12-bit accumulator and the carry-out pulse-density bit.
module wts_dsm1
    import wts_dac_pkg::*;
(
    input  logic        clk,
    input  logic        nreset,
    input  logic [11:0] scaled,
    output logic        dac
);

    logic [11:0] ff_scaled;
    logic [11:0] ff_acc;
    logic [12:0] sum;

    // The carry out of the 12-bit accumulator is the output density.
    assign sum = {1'b0, ff_acc} + {1'b0, ff_scaled};

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            ff_scaled <= WTS_MIDSCALE;
            ff_acc    <= 12'h000;
            dac       <= 1'b0;
        end else begin
            ff_scaled <= scaled;
            ff_acc    <= sum[11:0];
            dac       <= sum[12];
        end
    end

endmodule

// File: rtl/wts_dsm_dac.sv
// Two-channel delta-sigma DAC behind the channel mixer. With WTS_DAC_FADE_EN defined
// a soft-start/soft-mute gain ramp FSM is built; otherwise mute is immediate at unity gain.
module wts_dsm_dac
    import wts_dac_pkg::*;
(
    input  logic        nreset,
    input  logic        clk,
    input  logic        sample_en,
    input  logic [11:0] left_in,
    input  logic [11:0] right_in,
    input  logic        mute,
    output logic        left_dac,
    output logic        right_dac,
    output logic        muted
);

    logic [11:0] ff_left_smp;
    logic [11:0] ff_right_smp;
    logic [4:0]  ff_gain;
    logic [11:0] left_scaled;
    logic [11:0] right_scaled;

`ifdef WTS_DAC_FADE_EN
    wts_state_e  ff_state;
    logic [4:0]  gain_up;
    logic [4:0]  gain_dn;

    assign gain_up = (ff_gain >= WTS_GAIN_MAX) ? WTS_GAIN_MAX : ff_gain + 5'd1;
    assign gain_dn = (ff_gain == 5'd0) ? 5'd0 : ff_gain - 5'd1;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            ff_left_smp  <= WTS_MIDSCALE;
            ff_right_smp <= WTS_MIDSCALE;
        end else if (sample_en) begin
            ff_left_smp  <= left_in;
            ff_right_smp <= right_in;
        end
    end

    // Reset lands in FADE_IN at gain 0 so the output soft-starts.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            ff_state <= FADE_IN;
            ff_gain  <= 5'd0;
            muted    <= 1'b0;
        end else if (sample_en) begin
            case (ff_state)
                PLAY: begin
                    if (mute) begin
                        ff_state <= FADE_OUT;
                        ff_gain  <= gain_dn;
                    end
                end
                FADE_OUT: begin
                    if (!mute) begin
                        ff_state <= FADE_IN;
                        ff_gain  <= gain_up;
                    end else begin
                        ff_gain <= gain_dn;
                        if (gain_dn == 5'd0) begin
                            ff_state <= MUTED;
                            muted    <= 1'b1;
                        end
                    end
                end
                MUTED: begin
                    if (!mute) begin
                        ff_state <= FADE_IN;
                        ff_gain  <= gain_up;
                        muted    <= 1'b0;
                    end else begin
                        ff_gain <= 5'd0;
                    end
                end
                default: begin
                    if (mute) begin
                        ff_state <= FADE_OUT;
                        ff_gain  <= gain_dn;
                    end else begin
                        ff_gain <= gain_up;
                        if (gain_up == WTS_GAIN_MAX) ff_state <= PLAY;
                    end
                end
            endcase
        end
    end
`else
    assign ff_gain = WTS_GAIN_MAX;

    // Immediate mute: the captured samples themselves are forced to silence.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            ff_left_smp  <= WTS_MIDSCALE;
            ff_right_smp <= WTS_MIDSCALE;
            muted        <= 1'b0;
        end else if (sample_en) begin
            ff_left_smp  <= mute ? WTS_MIDSCALE : left_in;
            ff_right_smp <= mute ? WTS_MIDSCALE : right_in;
            muted        <= mute;
        end
    end
`endif

    assign left_scaled  = wts_scale(ff_left_smp, ff_gain);
    assign right_scaled = wts_scale(ff_right_smp, ff_gain);

    wts_dsm1 u_left (
        .clk    (clk),
        .nreset (nreset),
        .scaled (left_scaled),
        .dac    (left_dac)
    );

    wts_dsm1 u_right (
        .clk    (clk),
        .nreset (nreset),
        .scaled (right_scaled),
        .dac    (right_dac)
    );

endmodule

// File: tb/tb_wts_dsm_dac.sv
// Bench for wts_dsm_dac: behavioural model of gain ramp, scaling and modulator;
// exercises the fade FSM when WTS_DAC_FADE_EN is defined, immediate mute otherwise.
module tb_wts_dsm_dac;
    import wts_dac_pkg::*;

    logic        clk = 1'b0;
    logic        nreset = 1'b1;
    logic        sample_en = 1'b0;
    logic [11:0] left_in = 12'h800;
    logic [11:0] right_in = 12'h800;
    logic        mute = 1'b0;
    logic        left_dac;
    logic        right_dac;
    logic        muted;

    int n_cmp = 0;
    int n_fail = 0;

    // model state
    int m_smp_l, m_smp_r, m_gain, m_scl_l, m_scl_r, m_acc_l, m_acc_r;
    bit m_dac_l, m_dac_r, m_down, m_muted;

    wts_dsm_dac dut (
        .nreset    (nreset),
        .clk       (clk),
        .sample_en (sample_en),
        .left_in   (left_in),
        .right_in  (right_in),
        .mute      (mute),
        .left_dac  (left_dac),
        .right_dac (right_dac),
        .muted     (muted)
    );

    always #5 clk = ~clk;

    function automatic int model_scale(input int smp, input int g);
        int p;
        p = (smp - 2048) * g;
        if (p < 0) return 2048 - ((-p + 15) / 16);
        return 2048 + p / 16;
    endfunction

    function automatic wts_state_e model_state();
        if (m_muted) return MUTED;
        if (m_down) return FADE_OUT;
        if (m_gain == 16) return PLAY;
        return FADE_IN;
    endfunction

    task automatic model_reset();
        m_smp_l = 2048; m_smp_r = 2048;
`ifdef WTS_DAC_FADE_EN
        m_gain = 0;
`else
        m_gain = 16;
`endif
        m_scl_l = 2048; m_scl_r = 2048;
        m_acc_l = 0; m_acc_r = 0;
        m_dac_l = 0; m_dac_r = 0;
        m_down = 0; m_muted = 0;
    endtask

    // Advance one clock, update the model from the inputs seen at the edge, settle 1ns.
    task automatic tick();
        int sl, sr, ng;
        @(posedge clk);
        sl = m_acc_l + m_scl_l;
        sr = m_acc_r + m_scl_r;
        m_dac_l = (sl >= 4096); m_acc_l = sl % 4096;
        m_dac_r = (sr >= 4096); m_acc_r = sr % 4096;
        m_scl_l = model_scale(m_smp_l, m_gain);
        m_scl_r = model_scale(m_smp_r, m_gain);
        if (sample_en) begin
`ifdef WTS_DAC_FADE_EN
            m_smp_l = int'(left_in); m_smp_r = int'(right_in);
            if (mute) begin
                ng = (m_gain > 0) ? m_gain - 1 : 0;
                m_muted = m_down && (ng == 0);
                m_down = 1;
            end else begin
                ng = (m_gain < 16) ? m_gain + 1 : 16;
                m_muted = 0;
                m_down = 0;
            end
            m_gain = ng;
`else
            ng = 16;
            m_gain = ng;
            m_smp_l = mute ? 2048 : int'(left_in);
            m_smp_r = mute ? 2048 : int'(right_in);
            m_muted = mute;
`endif
        end
        #1;
    endtask

    task automatic strobe(input logic [11:0] l, input logic [11:0] r, input logic mu);
        left_in = l; right_in = r; mute = mu; sample_en = 1'b1;
        tick();
        sample_en = 1'b0;
    endtask

    task automatic test_reset();
        #2 nreset = 1'b0;
        model_reset();
        #2;
        n_cmp += 4;
        if (left_dac !== 1'b0) begin n_fail++; $display("FAIL reset_left_dac: got %b want 0", left_dac); end
        if (right_dac !== 1'b0) begin n_fail++; $display("FAIL reset_right_dac: got %b want 0", right_dac); end
        if (muted !== 1'b0) begin n_fail++; $display("FAIL reset_muted: got %b want 0", muted); end
        if (dut.ff_gain !== 5'(m_gain)) begin n_fail++; $display("FAIL reset_gain: got %0d want %0d", dut.ff_gain, m_gain); end
        #3;
        n_cmp += 1;
        if (dut.u_left.ff_scaled !== 12'h800) begin n_fail++; $display("FAIL reset_scaled: got %h want 800", dut.u_left.ff_scaled); end
`ifdef WTS_DAC_FADE_EN
        n_cmp += 1;
        if (dut.ff_state !== FADE_IN) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", dut.ff_state, FADE_IN); end
`endif
        #1 nreset = 1'b1;
    endtask

    task automatic test_soft_start();
        for (int k = 0; k < 16; k++) begin
            strobe(12'hC00, 12'($urandom_range(0, 4095)), 1'b0);
            n_cmp += 1;
            if (dut.ff_gain !== 5'(m_gain)) begin n_fail++; $display("FAIL soft_start_gain[%0d]: got %0d want %0d", k, dut.ff_gain, m_gain); end
            for (int c = 0; c < 5; c++) begin
                tick();
                n_cmp += 2;
                if (left_dac !== m_dac_l) begin n_fail++; $display("FAIL soft_start_left_dac: got %b want %b", left_dac, m_dac_l); end
                if (right_dac !== m_dac_r) begin n_fail++; $display("FAIL soft_start_right_dac: got %b want %b", right_dac, m_dac_r); end
            end
        end
        n_cmp += 2;
        if (dut.ff_gain !== 5'd16) begin n_fail++; $display("FAIL soft_start_final_gain: got %0d want 16", dut.ff_gain); end
        if (dut.u_left.ff_scaled !== 12'hC00) begin n_fail++; $display("FAIL soft_start_scaled: got %h want c00", dut.u_left.ff_scaled); end
`ifdef WTS_DAC_FADE_EN
        n_cmp += 1;
        if (dut.ff_state !== PLAY) begin n_fail++; $display("FAIL soft_start_state: got %0d want %0d", dut.ff_state, PLAY); end
`endif
    endtask

    task automatic test_patterns();
        int ones;
        strobe(12'h800, 12'h800, 1'b0);
        for (int c = 0; c < 24; c++) begin
            tick();
            n_cmp += 1;
            if (left_dac !== m_dac_l) begin n_fail++; $display("FAIL midscale_dac[%0d]: got %b want %b", c, left_dac, m_dac_l); end
        end
        strobe(12'h000, 12'h000, 1'b0);
        tick(); tick(); tick();
        for (int c = 0; c < 64; c++) begin
            tick();
            n_cmp += 1;
            if (left_dac !== 1'b0) begin n_fail++; $display("FAIL zero_dac[%0d]: got %b want 0", c, left_dac); end
        end
        strobe(12'hFFF, 12'hFFF, 1'b0);
        tick(); tick(); tick();
        ones = 0;
        for (int c = 0; c < 4096; c++) begin
            tick();
            ones += int'(left_dac);
        end
        n_cmp += 1;
        if (ones != 4095) begin n_fail++; $display("FAIL full_scale_ones: got %0d want 4095", ones); end
    endtask

`ifdef WTS_DAC_FADE_EN
    task automatic test_mute_fade();
        for (int k = 0; k < 16; k++) begin
            strobe(12'h800, 12'h800, 1'b1);
            n_cmp += 2;
            if (dut.ff_gain !== 5'(15 - k)) begin n_fail++; $display("FAIL fade_gain[%0d]: got %0d want %0d", k, dut.ff_gain, 15 - k); end
            if (muted !== (k == 15)) begin n_fail++; $display("FAIL fade_muted[%0d]: got %b want %b", k, muted, k == 15); end
            for (int c = 0; c < 5; c++) tick();
        end
        for (int c = 0; c < 12; c++) begin
            tick();
            n_cmp += 2;
            if (left_dac !== m_dac_l) begin n_fail++; $display("FAIL muted_dac[%0d]: got %b want %b", c, left_dac, m_dac_l); end
            if (dut.ff_state !== model_state()) begin n_fail++; $display("FAIL muted_state: got %0d want %0d", dut.ff_state, model_state()); end
        end
    endtask

    task automatic test_reversal();
        for (int k = 0; k < 16; k++) begin strobe(12'hC00, 12'h400, 1'b0); for (int c = 0; c < 5; c++) tick(); end
        for (int k = 0; k < 9; k++) begin strobe(12'hC00, 12'h400, 1'b1); for (int c = 0; c < 5; c++) tick(); end
        n_cmp += 3;
        if (dut.ff_gain !== 5'd7) begin n_fail++; $display("FAIL rev_gain7: got %0d want 7", dut.ff_gain); end
        if (dut.ff_state !== FADE_OUT) begin n_fail++; $display("FAIL rev_state_out: got %0d want %0d", dut.ff_state, FADE_OUT); end
        if (dut.u_left.ff_scaled !== 12'h9C0) begin n_fail++; $display("FAIL rev_scaled7: got %h want 9c0", dut.u_left.ff_scaled); end
        strobe(12'hC00, 12'h400, 1'b0);
        n_cmp += 2;
        if (dut.ff_gain !== 5'd8) begin n_fail++; $display("FAIL rev_gain8: got %0d want 8", dut.ff_gain); end
        if (dut.ff_state !== FADE_IN) begin n_fail++; $display("FAIL rev_state_in: got %0d want %0d", dut.ff_state, FADE_IN); end
        tick();
        n_cmp += 2;
        if (dut.u_left.ff_scaled !== 12'hA00) begin n_fail++; $display("FAIL rev_scaled8: got %h want a00", dut.u_left.ff_scaled); end
        if (dut.u_right.ff_scaled !== 12'(m_scl_r)) begin n_fail++; $display("FAIL rev_scaled8_r: got %h want %h", dut.u_right.ff_scaled, m_scl_r); end
    endtask
`else
    task automatic test_immediate_mute();
        strobe(12'h800, 12'h000, 1'b1);
        n_cmp += 2;
        if (dut.ff_right_smp !== 12'h800) begin n_fail++; $display("FAIL imm_captured: got %h want 800", dut.ff_right_smp); end
        if (muted !== 1'b1) begin n_fail++; $display("FAIL imm_muted: got %b want 1", muted); end
        tick(); tick();
        for (int c = 0; c < 12; c++) begin
            tick();
            n_cmp += 1;
            if (right_dac !== m_dac_r) begin n_fail++; $display("FAIL imm_right_dac[%0d]: got %b want %b", c, right_dac, m_dac_r); end
        end
        strobe(12'h800, 12'h123, 1'b0);
        n_cmp += 2;
        if (dut.ff_right_smp !== 12'h123) begin n_fail++; $display("FAIL imm_unmute_capture: got %h want 123", dut.ff_right_smp); end
        if (muted !== 1'b0) begin n_fail++; $display("FAIL imm_unmuted: got %b want 0", muted); end
    endtask
`endif

    task automatic test_between_strobes();
        strobe(12'h900, 12'h700, 1'b1);
        for (int c = 0; c < 12; c++) begin
            mute = c[0];
            tick();
            n_cmp += 2;
            if (dut.ff_gain !== 5'(m_gain)) begin n_fail++; $display("FAIL hold_gain[%0d]: got %0d want %0d", c, dut.ff_gain, m_gain); end
            if (muted !== m_muted) begin n_fail++; $display("FAIL hold_muted[%0d]: got %b want %b", c, muted, m_muted); end
`ifdef WTS_DAC_FADE_EN
            n_cmp += 1;
            if (dut.ff_state !== model_state()) begin n_fail++; $display("FAIL hold_state[%0d]: got %0d want %0d", c, dut.ff_state, model_state()); end
`endif
        end
    endtask

    task automatic test_random();
        logic mu;
        mu = 1'b0;
        for (int f = 0; f < 150; f++) begin
            if ($urandom_range(0, 7) == 0) mu = ~mu;
            strobe(12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)), mu);
            n_cmp += 2;
            if (dut.ff_gain !== 5'(m_gain)) begin n_fail++; $display("FAIL rnd_gain[%0d]: got %0d want %0d", f, dut.ff_gain, m_gain); end
            if (muted !== m_muted) begin n_fail++; $display("FAIL rnd_muted[%0d]: got %b want %b", f, muted, m_muted); end
`ifdef WTS_DAC_FADE_EN
            n_cmp += 1;
            if (dut.ff_state !== model_state()) begin n_fail++; $display("FAIL rnd_state[%0d]: got %0d want %0d", f, dut.ff_state, model_state()); end
`endif
            for (int c = 0; c < 5; c++) begin
                tick();
                n_cmp += 2;
                if (left_dac !== m_dac_l) begin n_fail++; $display("FAIL rnd_left_dac[%0d]: got %b want %b", f, left_dac, m_dac_l); end
                if (right_dac !== m_dac_r) begin n_fail++; $display("FAIL rnd_right_dac[%0d]: got %b want %b", f, right_dac, m_dac_r); end
            end
        end
    endtask

    task automatic test_reset_mid_fade();
        for (int k = 0; k < 4; k++) begin strobe(12'hFF0, 12'hF00, 1'b0); for (int c = 0; c < 5; c++) tick(); end
        for (int k = 0; k < 3; k++) begin strobe(12'hFF0, 12'hF00, 1'b1); for (int c = 0; c < 5; c++) tick(); end
        nreset = 1'b0;
        model_reset();
        #1;
        n_cmp += 5;
        if (left_dac !== 1'b0) begin n_fail++; $display("FAIL midrst_left_dac: got %b want 0", left_dac); end
        if (right_dac !== 1'b0) begin n_fail++; $display("FAIL midrst_right_dac: got %b want 0", right_dac); end
        if (muted !== 1'b0) begin n_fail++; $display("FAIL midrst_muted: got %b want 0", muted); end
        if (dut.ff_gain !== 5'(m_gain)) begin n_fail++; $display("FAIL midrst_gain: got %0d want %0d", dut.ff_gain, m_gain); end
        if (dut.u_left.ff_scaled !== 12'h800) begin n_fail++; $display("FAIL midrst_scaled: got %h want 800", dut.u_left.ff_scaled); end
`ifdef WTS_DAC_FADE_EN
        n_cmp += 1;
        if (dut.ff_state !== FADE_IN) begin n_fail++; $display("FAIL midrst_state: got %0d want %0d", dut.ff_state, FADE_IN); end
`endif
        #2 nreset = 1'b1;
        for (int c = 0; c < 12; c++) begin
            tick();
            n_cmp += 1;
            if (left_dac !== m_dac_l) begin n_fail++; $display("FAIL midrst_after_dac[%0d]: got %b want %b", c, left_dac, m_dac_l); end
        end
    endtask

    initial begin
        test_reset();
        test_soft_start();
        test_patterns();
`ifdef WTS_DAC_FADE_EN
        test_mute_fade();
        test_reversal();
`else
        test_immediate_mute();
`endif
        test_between_strobes();
        test_random();
        test_reset_mid_fade();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
